// File: rtl/axis_packetizer.sv
// axis_packetizer: frames a continuous AXI4-Stream sample stream into
// fixed-length packets. Each packet is one generated header word
// {SRC_ID, seq} followed by FRAME_LEN payload beats, the last one carrying tlast.
//
// Handshake semantics (both ports): a beat transfers on a rising edge where
// tvalid && tready. Once output_axis_tvalid is high it stays high, with
// tdata/tlast/tuser frozen, until that transfer happens. input_axis_tready
// depends combinationally on output_axis_tready through load_ok.
module axis_packetizer #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAME_LEN  = 16,
   parameter int ID_WIDTH   = 4,
   parameter int SRC_ID     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] input_axis_tdata,
   input  logic                  input_axis_tvalid,
   output logic                  input_axis_tready,
   input  logic                  input_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_axis_tdata,
   output logic                  output_axis_tvalid,
   input  logic                  output_axis_tready,
   output logic                  output_axis_tlast,
   output logic                  output_axis_tuser,
   output logic                  frame_done,
   output logic                  busy
);

   localparam int                  SEQ_WIDTH = DATA_WIDTH - ID_WIDTH;
   localparam logic [ID_WIDTH-1:0] SRC_FIELD = ID_WIDTH'(SRC_ID);
   localparam logic [15:0]         LAST_CNT  = 16'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      PAYLOAD = 1'b1
   } state_t;

   state_t                  state, next_state;
   logic [SEQ_WIDTH-1:0]    seq;
   logic [15:0]             beat_cnt;
   logic                    err_sticky;

   logic                    out_valid;
   logic [DATA_WIDTH-1:0]   out_data;
   logic                    out_last;
   logic                    out_user;
   logic                    done_q;

   logic                    load_ok;
   logic                    hdr_load;
   logic                    pay_load;
   logic                    last_beat;

   // The output register can take a new beat when empty or draining this cycle.
   assign load_ok = !out_valid || output_axis_tready;

   // FSM state register; reset abandons any open frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state and load decisions.
   always_comb begin
      next_state        = state;
      input_axis_tready = 1'b0;
      hdr_load          = 1'b0;
      pay_load          = 1'b0;
      last_beat         = 1'b0;
      case (state)
         IDLE: begin
            // Header is only emitted once payload is actually waiting, so an
            // opened frame can always proceed.
            if (enable && input_axis_tvalid && load_ok) begin
               hdr_load   = 1'b1;
               next_state = PAYLOAD;
            end
         end
         PAYLOAD: begin
            input_axis_tready = load_ok;
            if (input_axis_tvalid && load_ok) begin
               pay_load = 1'b1;
               if (beat_cnt == LAST_CNT) begin
                  last_beat  = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output register: header or payload load, else drain on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_user  <= 1'b0;
      end else if (hdr_load) begin
         out_valid <= 1'b1;
         out_data  <= {SRC_FIELD, seq};
         out_last  <= 1'b0;
         out_user  <= 1'b0;
      end else if (pay_load) begin
         out_valid <= 1'b1;
         out_data  <= input_axis_tdata;
         out_last  <= last_beat;
         out_user  <= last_beat & (err_sticky | input_axis_tuser);
      end else if (output_axis_tready) begin
         out_valid <= 1'b0;
      end
   end

   // Frame bookkeeping: beat counter, sticky error, sequence number, done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq        <= '0;
         beat_cnt   <= '0;
         err_sticky <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= pay_load && last_beat;
         if (pay_load) begin
            if (last_beat) begin
               beat_cnt   <= '0;
               err_sticky <= 1'b0;
               seq        <= seq + 1'b1;
            end else begin
               beat_cnt   <= beat_cnt + 16'd1;
               err_sticky <= err_sticky | input_axis_tuser;
            end
         end
      end
   end

   assign output_axis_tvalid = out_valid;
   assign output_axis_tdata  = out_data;
   assign output_axis_tlast  = out_last;
   assign output_axis_tuser  = out_user;
   // frame_done rises together with the tlast beat appearing in the register.
   assign frame_done         = done_q;
   // With two states, busy is a full view of the FSM state.
   assign busy               = (state != IDLE);

endmodule

// File: tb/tb_axis_packetizer.sv
// tb_axis_packetizer: directed self-checking bench for axis_packetizer with
// FRAME_LEN=4, SRC_ID=3, ID_WIDTH=4, DATA_WIDTH=8.
module tb_axis_packetizer;

   localparam int DW        = 8;
   localparam int FRAME_LEN = 4;
   localparam int TIMEOUT   = 200;
   localparam logic [3:0] SRC_NIB = 4'd3;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic [DW-1:0] input_axis_tdata;
   logic          input_axis_tvalid;
   logic          input_axis_tready;
   logic          input_axis_tuser;
   logic [DW-1:0] output_axis_tdata;
   logic          output_axis_tvalid;
   logic          output_axis_tready;
   logic          output_axis_tlast;
   logic          output_axis_tuser;
   logic          frame_done;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: {tuser, tlast, tdata} per expected output beat
   logic [DW+1:0] exp_q[$];

   // reference model state
   int         m_beat   = 0;
   logic [3:0] m_seq    = 4'd0;
   logic       m_err    = 1'b0;
   int         m_frames = 0;
   int         done_cnt = 0;

   logic          rand_ready   = 1'b0;
   logic          hold_pending = 1'b0;
   logic [DW+1:0] held;

   axis_packetizer #(
      .DATA_WIDTH (DW),
      .FRAME_LEN  (FRAME_LEN),
      .ID_WIDTH   (4),
      .SRC_ID     (3)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .enable             (enable),
      .input_axis_tdata   (input_axis_tdata),
      .input_axis_tvalid  (input_axis_tvalid),
      .input_axis_tready  (input_axis_tready),
      .input_axis_tuser   (input_axis_tuser),
      .output_axis_tdata  (output_axis_tdata),
      .output_axis_tvalid (output_axis_tvalid),
      .output_axis_tready (output_axis_tready),
      .output_axis_tlast  (output_axis_tlast),
      .output_axis_tuser  (output_axis_tuser),
      .frame_done         (frame_done),
      .busy               (busy)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Push expected beats for one payload word, then drive it until accepted.
   task automatic send_payload(input logic [DW-1:0] d, input logic u);
      logic last;
      int   n;
      if (m_beat == 0) exp_q.push_back({2'b00, SRC_NIB, m_seq});
      last = (m_beat == FRAME_LEN - 1);
      exp_q.push_back({last & (m_err | u), last, d});
      if (last) begin
         m_beat = 0;
         m_err  = 1'b0;
         m_seq  = m_seq + 4'd1;
         m_frames++;
      end else begin
         m_beat++;
         m_err = m_err | u;
      end
      input_axis_tdata  = d;
      input_axis_tuser  = u;
      input_axis_tvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (input_axis_tready) break;
         n++;
         if (n > TIMEOUT) begin
            check("in_accept_timeout", input_axis_tready, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      input_axis_tvalid = 1'b0;
      input_axis_tuser  = 1'b0;
   endtask

   task automatic send_frame(input logic [DW-1:0] base, input int err_idx);
      for (int i = 0; i < FRAME_LEN; i++)
         send_payload(base + DW'(i), (i == err_idx));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      check("queue_drained", exp_q.size(), 0);
   endtask

   // random downstream backpressure
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) output_axis_tready = 1'($urandom_range(0, 1));
      end
   end

   // monitor: scoreboard pop on handshake, stall stability, done alignment
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            check("stall_valid", output_axis_tvalid, 1);
            check("stall_beat", {output_axis_tuser, output_axis_tlast, output_axis_tdata}, held);
         end
         if (output_axis_tvalid && output_axis_tready) begin
            if (exp_q.size() == 0)
               check("unexpected_beat", output_axis_tvalid, 0);
            else
               check("out_beat", {output_axis_tuser, output_axis_tlast, output_axis_tdata},
                     exp_q.pop_front());
         end
         hold_pending = output_axis_tvalid && !output_axis_tready;
         held = {output_axis_tuser, output_axis_tlast, output_axis_tdata};
         if (frame_done) begin
            done_cnt++;
            check("done_with_last", {output_axis_tvalid, output_axis_tlast}, 2'b11);
         end
      end
   end

   initial begin
      rst_n              = 1'b0;
      enable             = 1'b0;
      input_axis_tdata   = '0;
      input_axis_tvalid  = 1'b0;
      input_axis_tuser   = 1'b0;
      output_axis_tready = 1'b1;

      // reset state
      #2;
      check("rst_tvalid", output_axis_tvalid, 0);
      check("rst_tdata", output_axis_tdata, 0);
      check("rst_tlast", output_axis_tlast, 0);
      check("rst_tuser", output_axis_tuser, 0);
      check("rst_done", frame_done, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", input_axis_tready, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic framing: 0x30,0x10..0x13 then 0x31,0x14..0x17
      enable = 1'b1;
      send_payload(8'h10, 1'b0);
      check("latency_first_beat", output_axis_tdata, 8'h10);
      for (int i = 1; i < 8; i++) send_payload(8'h10 + DW'(i), 1'b0);
      wait_drain();
      repeat (2) @(negedge clk);
      check("basic_done_count", done_cnt, 2);

      // error flag on payload beat 2 of the first frame only
      send_frame(8'h40, 2);
      send_frame(8'h50, -1);
      wait_drain();

      // enable dropped after the header: frame still completes, then stays idle
      send_payload(8'h60, 1'b0);
      enable = 1'b0;
      for (int i = 1; i < FRAME_LEN; i++) send_payload(8'h60 + DW'(i), 1'b0);
      input_axis_tvalid = 1'b1;
      input_axis_tdata  = 8'hee;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("en_low_busy", busy, 0);
         check("en_low_in_ready", input_axis_tready, 0);
         if (i >= 2) check("en_low_out_valid", output_axis_tvalid, 0);
      end
      @(posedge clk);
      #1;
      input_axis_tvalid = 1'b0;
      enable = 1'b1;
      wait_drain();

      // reset mid-frame after 2 payload beats
      send_payload(8'h70, 1'b0);
      send_payload(8'h71, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_tvalid", output_axis_tvalid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", input_axis_tready, 0);
      exp_q.delete();
      m_beat = 0;
      m_err  = 1'b0;
      m_seq  = 4'd0;
      repeat (2) @(negedge clk);
      check("midrst_tvalid_held", output_axis_tvalid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // header after reset must be 0x30
      send_frame(8'h80, -1);

      // sequence wrap: 16 more frames take seq 1..15 then 0
      for (int f = 0; f < 16; f++) send_frame(8'(f * 4), -1);
      wait_drain();

      // backpressure: 200 frames = 1000 output beats, random input gaps
      rand_ready = 1'b1;
      for (int f = 0; f < 200; f++) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            repeat ($urandom_range(0, 1)) begin
               @(posedge clk);
               #1;
            end
            send_payload(8'($urandom_range(0, 255)), 1'($urandom_range(0, 9) == 0));
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      output_axis_tready = 1'b1;
      wait_drain();
      repeat (3) @(negedge clk);
      check("frame_done_total", done_cnt, m_frames);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

Upstream framing stage for the arbitrated stream mux: turns a continuous AXI4-Stream sample stream into fixed-length frames, each beginning with a generated header word (source ID plus sequence number) and terminated by tlast. Because the mux arbitrates on tlast, this block must always close a frame it has opened. A registered output stage gives one cycle of latency and full throughput.

## Interface
- DATA_WIDTH, 8: tdata width; must be greater than ID_WIDTH.
- FRAME_LEN, 16: payload beats per frame, excluding the header; legal range 1..65535.
- ID_WIDTH, 4: width of the source-ID field in the header.
- SRC_ID, 0: constant source ID placed in header bits [DATA_WIDTH-1 -: ID_WIDTH].
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  allows new frames to start; sampled only in IDLE.
- input_axis_tdata  in  DATA_WIDTH  payload data.
- input_axis_tvalid  in  1  payload valid.
- input_axis_tready  out  1  payload accepted.
- input_axis_tuser  in  1  per-beat error flag.
- output_axis_tdata  out  DATA_WIDTH  header or payload.
- output_axis_tvalid  out  1  output valid.
- output_axis_tready  in  1  downstream ready.
- output_axis_tlast  out  1  last payload beat of the frame.
- output_axis_tuser  out  1  frame-error flag; meaningful only on the tlast beat.
- frame_done  out  1  one-cycle pulse when the tlast beat is loaded into the output register.
- busy  out  1  high while state is not IDLE.

## Operation
- Output register: out_valid, out_data, out_last, out_user. It may load when `load_ok = !out_valid || output_axis_tready`.
- FSM states: IDLE, PAYLOAD.
  - IDLE:
    - input_axis_tready = 0.
    - If enable && input_axis_tvalid && load_ok, load the header beat and go to PAYLOAD.
    - Header beat: tdata = {SRC_ID[ID_WIDTH-1:0], seq}; tlast = 0; tuser = 0.
  - PAYLOAD:
    - input_axis_tready = load_ok (combinational path from output_axis_tready).
    - Each accepted beat is loaded into the output register; beat_cnt increments.
    - On the beat where beat_cnt == FRAME_LEN-1:
      - tlast = 1 and tuser = err_sticky | input_axis_tuser.
      - seq increments; beat_cnt and err_sticky clear; frame_done pulses.
      - Return to IDLE.
- seq is DATA_WIDTH-ID_WIDTH bits wide and wraps modulo 2^(DATA_WIDTH-ID_WIDTH) with no saturation.
- beat_cnt is 16 bits.
- err_sticky is set by any accepted payload beat with input_axis_tuser = 1. It is reported only on the tlast beat and cleared at frame end.
- Deasserting enable mid-frame has no effect: the frame always completes with FRAME_LEN payload beats.
- If the input stalls (tvalid low) mid-frame, the block waits indefinitely. No timeout and no padding.
- When output_axis_tvalid = 0 the output register holds its previous data; don't-care data is allowed, valid must be 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - Outputs: output_axis_tvalid = 0, tdata = 0, tlast = 0, tuser = 0, frame_done = 0, busy = 0, input_axis_tready = 0.
  - Internal: state = IDLE, seq = 0, beat_cnt = 0, err_sticky = 0.
- Reset mid-frame abandons the frame immediately; output_axis_tvalid drops asynchronously. The next frame's header carries seq = 0.
- Latency: an input beat accepted in cycle N appears on the output in cycle N+1. The header appears the cycle after its IDLE load condition is met.
- Throughput:
  - With output_axis_tready held high, one frame takes FRAME_LEN+1 cycles.
  - Back-to-back frames are possible: the IDLE header load can occur in the cycle immediately after the tlast load.
- AXI rules:
  - output_axis_tvalid never drops without a handshake (except on reset).
  - Data and sideband signals are stable while valid && !ready.
- Simultaneous events: when the output holds a beat, output_axis_tready = 1 and a new beat arrives in the same cycle, the register drains and reloads in that cycle with no bubble.

## Test plan
- Basic framing:
  - Stimulus: FRAME_LEN=4, SRC_ID=3, ID_WIDTH=4, DATA_WIDTH=8, tready=1, enable=1, input words 0x10..0x17.
  - Required output: 0x30, 0x10, 0x11, 0x12, 0x13(tlast); then 0x31, 0x14..0x17(tlast). frame_done pulses twice.
- Backpressure:
  - Stimulus: random output_axis_tready at 50%, 1000 beats.
  - Required: no beat lost or duplicated; data stable under stall; header every 5th beat.
- Sequence wrap:
  - Stimulus: 17 frames with DATA_WIDTH=8, ID_WIDTH=4.
  - Required: header low nibbles 0..15, then 0 again.
- Error flag:
  - Stimulus: tuser=1 on payload beat 2 of frame 0 only.
  - Required: frame 0's tlast beat has tuser=1; frame 1's tlast beat has tuser=0.
- Enable mid-frame:
  - Stimulus: drop enable after header.
  - Required: the full frame completes with tlast, then no new header while enable=0 even with input_axis_tvalid=1.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after 2 payload beats, then release.
  - Required: tvalid=0 during reset; next header = 0x30.
